// File: rtl/control_unit.sv
// control_unit: hardwired T-step sequencer for the mini-CPU datapath.
// Strobes, op and Run are registered from the next state, so each step's strobes are valid for that whole cycle.
`default_nettype none

module control_unit (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        branchCompare,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        Write,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        ZHighin,
    output logic        Zlowin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIOut,
    output logic        LOout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAOut,
    output logic        Cout,
    output logic        CONin,
    output logic        InPortout,
    output logic        OutPortin,
    output logic [4:0]  op,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc, mar_in, read, write, mdr_in, mdr_out, ir_in;
        logic y_in, zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out;
        logic gra, grb, grc, r_in, r_out, ba_out, c_out, con_in, inport_out, outport_in;
    } strobes_t;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01011;
    localparam logic [4:0] OPC_ANDI = 5'b01100;
    localparam logic [4:0] OPC_ORI  = 5'b01101;
    localparam logic [4:0] OPC_MUL  = 5'b01110;
    localparam logic [4:0] OPC_DIV  = 5'b01111;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_IN   = 5'b10101;
    localparam logic [4:0] OPC_OUT  = 5'b10110;
    localparam logic [4:0] OPC_MFHI = 5'b10111;
    localparam logic [4:0] OPC_MFLO = 5'b11000;
    localparam logic [4:0] OPC_HALT = 5'b11010;

    state_t     state_q, state_d;
    logic [4:0] opcode_q, opcode_d;
    strobes_t   strobes_q, strobes_d;
    logic [4:0] op_q, op_d;
    logic       run_q, run_d;

    logic       is_reg, is_imm, is_ldi, is_mem, is_muldiv, is_br;
    logic [4:0] imm_op;
    logic       unused_ir_bits;

    assign unused_ir_bits = ^ir[26:0];

    // Instruction class decode; opcode_d already carries ir's opcode on the edge into T3.
    assign is_reg    = (opcode_d >= 5'b00011) && (opcode_d <= 5'b01010);
    assign is_imm    = (opcode_d == OPC_ADDI) || (opcode_d == OPC_ANDI) || (opcode_d == OPC_ORI);
    assign is_ldi    = (opcode_d == OPC_LDI);
    assign is_mem    = (opcode_d == OPC_LD) || (opcode_d == OPC_ST);
    assign is_muldiv = (opcode_d == OPC_MUL) || (opcode_d == OPC_DIV);
    assign is_br     = (opcode_d == OPC_BR);
    assign imm_op    = (opcode_d == OPC_ADDI) ? OPC_ADD :
                       (opcode_d == OPC_ANDI) ? OPC_AND : OPC_OR;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2: begin
                state_d  = S_T3;
                opcode_d = ir[31:27];
            end
            S_T3: begin
                if (opcode_q == OPC_HALT)
                    state_d = S_HALT;
                else if (is_reg || is_imm || is_ldi || is_mem || is_muldiv || is_br)
                    state_d = S_T4;
                else
                    state_d = S_T0;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_mem || is_muldiv || is_br) ? S_T6 : S_T0;
            S_T6:   state_d = is_mem ? S_T7 : S_T0;
            S_T7:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        strobes_d = '0;
        op_d      = 5'b00000;
        run_d     = (state_d != S_HALT);
        case (state_d)
            S_T0: begin
                strobes_d.pc_out   = 1'b1;
                strobes_d.mar_in   = 1'b1;
                strobes_d.inc_pc   = 1'b1;
                strobes_d.zhigh_in = 1'b1;
                strobes_d.zlow_in  = 1'b1;
            end
            S_T1: begin
                strobes_d.zlow_out = 1'b1;
                strobes_d.pc_in    = 1'b1;
                strobes_d.read     = 1'b1;
                strobes_d.mdr_in   = 1'b1;
            end
            S_T2: begin
                strobes_d.mdr_out = 1'b1;
                strobes_d.ir_in   = 1'b1;
            end
            S_T3: begin
                if (is_reg || is_imm) begin
                    strobes_d.grb = 1'b1; strobes_d.r_out = 1'b1; strobes_d.y_in = 1'b1;
                end else if (is_ldi || is_mem) begin
                    strobes_d.grb = 1'b1; strobes_d.ba_out = 1'b1; strobes_d.y_in = 1'b1;
                end else if (is_muldiv) begin
                    strobes_d.gra = 1'b1; strobes_d.r_out = 1'b1; strobes_d.y_in = 1'b1;
                end else if (is_br) begin
                    strobes_d.gra = 1'b1; strobes_d.r_out = 1'b1; strobes_d.con_in = 1'b1;
                end else if (opcode_d == OPC_MFHI) begin
                    strobes_d.hi_out = 1'b1; strobes_d.gra = 1'b1; strobes_d.r_in = 1'b1;
                end else if (opcode_d == OPC_MFLO) begin
                    strobes_d.lo_out = 1'b1; strobes_d.gra = 1'b1; strobes_d.r_in = 1'b1;
                end else if (opcode_d == OPC_IN) begin
                    strobes_d.inport_out = 1'b1; strobes_d.gra = 1'b1; strobes_d.r_in = 1'b1;
                end else if (opcode_d == OPC_OUT) begin
                    strobes_d.gra = 1'b1; strobes_d.r_out = 1'b1; strobes_d.outport_in = 1'b1;
                end
            end
            S_T4: begin
                if (is_br) begin
                    strobes_d.pc_out = 1'b1; strobes_d.y_in = 1'b1;
                end else begin
                    strobes_d.zhigh_in = 1'b1;
                    strobes_d.zlow_in  = 1'b1;
                    if (is_reg) begin
                        strobes_d.grc = 1'b1; strobes_d.r_out = 1'b1; op_d = opcode_d;
                    end else if (is_imm) begin
                        strobes_d.c_out = 1'b1; op_d = imm_op;
                    end else if (is_muldiv) begin
                        strobes_d.grb = 1'b1; strobes_d.r_out = 1'b1; op_d = opcode_d;
                    end else begin
                        strobes_d.c_out = 1'b1; op_d = OPC_ADD;
                    end
                end
            end
            S_T5: begin
                if (is_br) begin
                    strobes_d.c_out = 1'b1; strobes_d.zhigh_in = 1'b1;
                    strobes_d.zlow_in = 1'b1; op_d = OPC_ADD;
                end else begin
                    strobes_d.zlow_out = 1'b1;
                    if (is_mem)         strobes_d.mar_in = 1'b1;
                    else if (is_muldiv) strobes_d.lo_in  = 1'b1;
                    else begin
                        strobes_d.gra = 1'b1; strobes_d.r_in = 1'b1;
                    end
                end
            end
            S_T6: begin
                if (opcode_d == OPC_LD) begin
                    strobes_d.read = 1'b1; strobes_d.mdr_in = 1'b1;
                end else if (opcode_d == OPC_ST) begin
                    strobes_d.gra = 1'b1; strobes_d.r_out = 1'b1; strobes_d.mdr_in = 1'b1;
                end else if (is_muldiv) begin
                    strobes_d.zhigh_out = 1'b1; strobes_d.hi_in = 1'b1;
                end else if (is_br && branchCompare) begin
                    // CON result is taken on the edge that enters T6.
                    strobes_d.zlow_out = 1'b1; strobes_d.pc_in = 1'b1;
                end
            end
            S_T7: begin
                if (opcode_d == OPC_LD) begin
                    strobes_d.mdr_out = 1'b1; strobes_d.gra = 1'b1; strobes_d.r_in = 1'b1;
                end else begin
                    strobes_d.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_RST;
            opcode_q  <= 5'b00000;
            strobes_q <= '0;
            op_q      <= 5'b00000;
            run_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            strobes_q <= strobes_d;
            op_q      <= op_d;
            run_q     <= run_d;
        end
    end

    assign {PCout, PCin, IncPC, MARin, Read, Write, MDRin, MDRout, IRin,
            Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin, HIOut, LOout,
            Gra, Grb, Grc, Rin, Rout, BAOut, Cout, CONin, InPortout, OutPortin} = strobes_q;
    assign op  = op_q;
    assign Run = run_q;

endmodule

`default_nettype wire
